// File: rtl/led_pwm_bank.sv
// Multi-channel LED PWM driver with per-channel OFF/ON/BLINK/BREATHE modes.
// Config writes land in a pending slot and are promoted to active on each frame wrap.
module led_pwm_bank #(
  parameter int CHANNELS     = 4,
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 16,
  parameter int BLINK_FRAMES = 3906,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WR_EN,
  input  logic [CH_W-1:0]     WR_CH,
  input  logic [1:0]          WR_MODE,
  input  logic [PWM_BITS-1:0] WR_DUTY,
  output logic [CHANNELS-1:0] LED,
  output logic                FRAME
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(CHANNELS);
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [PS_W-1:0]     pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FC_W-1:0]     frame_cnt;
  logic                blink_phase;
  logic [PWM_BITS-1:0] breathe_lvl;
  dir_t                breathe_dir;

  mode_t               pend_mode [CHANNELS];
  logic [PWM_BITS-1:0] pend_duty [CHANNELS];
  mode_t               act_mode  [CHANNELS];
  logic [PWM_BITS-1:0] act_duty  [CHANNELS];

  logic                step;
  logic                wrap;
  logic                wr_hit;
  logic [CHANNELS-1:0] lit;

  assign step   = (pre_cnt == PS_LAST);
  assign wrap   = step && (pwm_cnt == '1);
  assign wr_hit = WR_EN && ({1'b0, WR_CH} < CH_LIMIT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      FRAME   <= 1'b0;
    end else begin
      pre_cnt <= step ? '0 : pre_cnt + 1'b1;
      if (step) pwm_cnt <= pwm_cnt + 1'b1;
      FRAME <= wrap;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Direction flips as the endpoint is left, so 0 and max each last a single frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      breathe_lvl <= '0;
      breathe_dir <= DIR_UP;
    end else if (wrap) begin
      if (breathe_dir == DIR_UP) begin
        if (breathe_lvl == '1) begin
          breathe_dir <= DIR_DOWN;
          breathe_lvl <= breathe_lvl - 1'b1;
        end else begin
          breathe_lvl <= breathe_lvl + 1'b1;
        end
      end else begin
        if (breathe_lvl == '0) begin
          breathe_dir <= DIR_UP;
          breathe_lvl <= breathe_lvl + 1'b1;
        end else begin
          breathe_lvl <= breathe_lvl - 1'b1;
        end
      end
    end
  end

  // Active samples pending before this edge's write lands, so a boundary write waits a frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        pend_mode[i] <= MODE_OFF;
        pend_duty[i] <= '0;
        act_mode[i]  <= MODE_OFF;
        act_duty[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (wr_hit && (WR_CH == CH_W'(i))) begin
          pend_mode[i] <= mode_t'(WR_MODE);
          pend_duty[i] <= WR_DUTY;
        end
        if (wrap) begin
          act_mode[i] <= pend_mode[i];
          act_duty[i] <= pend_duty[i];
        end
      end
    end
  end

  always_comb begin
    lit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      case (act_mode[i])
        MODE_ON:      lit[i] = 1'b1;
        MODE_BLINK:   lit[i] = blink_phase && (pwm_cnt < act_duty[i]);
        MODE_BREATHE: lit[i] = (pwm_cnt < breathe_lvl);
        default:      lit[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) LED <= '0;
    else     LED <= lit;
  end

endmodule
